// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer and its flush timer.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_FLUSH  = 2'd2,
    FETCH_HALTED = 2'd3
  } fetch_state_t;

  localparam int unsigned DEF_ADDR_W       = 7;
  localparam int unsigned DEF_FLUSH_CYCLES = 2;
  localparam int unsigned FLUSH_CNT_W      = 3;
  localparam int unsigned PERF_W           = 16;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == '1) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/fetch_flush_timer.sv
// Loadable down-counter with a nonzero flag; times flush windows and mispredict recovery.
module fetch_flush_timer
  import fetch_pkg::*;
#(
  parameter int unsigned W = FLUSH_CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy_o
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign busy_o = (count != '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: sequential addressing, branch redirect with timed flush, halt.
// Optional FETCH_SEQ_PERF_EN adds saturating fetch/redirect counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W       = DEF_ADDR_W,
  parameter int unsigned          FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter logic [ADDR_W-1:0]    START_ADDR   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stall,
  input  logic              halt,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic              flush,
  output logic              busy,
  output logic              done
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0] fetch_count,
  output logic [PERF_W-1:0] redirect_count
`endif
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic              valid_d, flush_d, busy_d, done_d;
  logic              timer_load, timer_busy, start_run;

  // Timer holds FLUSH_CYCLES-1 after the redirect edge; exit occurs on the edge it reads zero.
  fetch_flush_timer #(.W(FLUSH_CNT_W)) u_flush_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (FLUSH_CNT_W'(FLUSH_CYCLES - 1)),
    .busy_o   (timer_busy)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = fetch_addr;
    valid_d    = fetch_valid;
    flush_d    = flush;
    done_d     = done;
    timer_load = 1'b0;
    start_run  = 1'b0;
    unique case (state_q)
      FETCH_IDLE: begin
        valid_d   = 1'b0;
        start_run = start;
      end
      FETCH_HALTED: begin
        valid_d   = 1'b0;
        start_run = start;
      end
      FETCH_RUN: begin
        if (branch_taken) begin
          addr_d     = branch_target;
          valid_d    = 1'b0;
          flush_d    = 1'b1;
          timer_load = 1'b1;
          state_d    = FETCH_FLUSH;
        end else if (halt) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = FETCH_HALTED;
        end else if (!stall) begin
          addr_d  = fetch_addr + ADDR_W'(1);
          valid_d = 1'b1;
        end
      end
      FETCH_FLUSH: begin
        valid_d = 1'b0;
        flush_d = 1'b1;
        if (!timer_busy) begin
          flush_d = 1'b0;
          valid_d = 1'b1;
          state_d = FETCH_RUN;
        end
      end
    endcase
    if (start_run) begin
      state_d = FETCH_RUN;
      addr_d  = START_ADDR;
      valid_d = 1'b1;
      done_d  = 1'b0;
    end
    busy_d = (state_d == FETCH_RUN) || (state_d == FETCH_FLUSH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FETCH_IDLE;
      fetch_addr  <= '0;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_addr  <= addr_d;
      fetch_valid <= valid_d;
      flush       <= flush_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else if (start_run) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (fetch_valid) fetch_count    <= sat_inc(fetch_count);
      if (timer_load)  redirect_count <= sat_inc(redirect_count);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic vs a cycle model.
module tb_fetch_sequencer;

  localparam int unsigned    ADDR_W = 7;
  localparam int unsigned    FLUSH  = 2;
  localparam logic [6:0]     START  = 7'd0;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0, stall = 1'b0, halt = 1'b0, branch_taken = 1'b0;
  logic [6:0] branch_target = '0;
  logic [6:0] fetch_addr;
  logic       fetch_valid, flush, busy, done;

  fetch_sequencer #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(FLUSH), .START_ADDR(START)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .stall         (stall),
    .halt          (halt),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .fetch_addr    (fetch_addr),
    .fetch_valid   (fetch_valid),
    .flush         (flush),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: "active" means a program is in flight; flush_left counts flush cycles still owed.
  logic [6:0] m_addr = '0;
  logic       m_valid = 1'b0, m_active = 1'b0, m_done = 1'b0;
  int         m_flush_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_addr = '0; m_valid = 1'b0; m_active = 1'b0; m_done = 1'b0; m_flush_left = 0;
  endtask

  task automatic model_edge(input logic st, input logic sl, input logic hl,
                            input logic br, input logic [6:0] tg);
    if (!m_active) begin
      m_valid = 1'b0;
      if (st) begin
        m_active = 1'b1; m_done = 1'b0; m_addr = START; m_valid = 1'b1;
      end
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      m_valid = (m_flush_left == 0);
    end else if (br) begin
      m_addr = tg; m_valid = 1'b0; m_flush_left = FLUSH;
    end else if (hl) begin
      m_active = 1'b0; m_done = 1'b1; m_valid = 1'b0;
    end else if (!sl) begin
      m_addr = m_addr + 7'd1; m_valid = 1'b1;
    end
  endtask

  task automatic tick(input logic st, input logic sl, input logic hl,
                      input logic br, input logic [6:0] tg);
    start = st; stall = sl; halt = hl; branch_taken = br; branch_target = tg;
    @(posedge clk);
    if (reset_n) model_edge(st, sl, hl, br, tg);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [6:0] a, input logic v,
                            input logic f, input logic b, input logic d);
    check({tag, ".addr"},  32'(fetch_addr),  32'(a));
    check({tag, ".valid"}, 32'(fetch_valid), 32'(v));
    check({tag, ".flush"}, 32'(flush),       32'(f));
    check({tag, ".busy"},  32'(busy),        32'(b));
    check({tag, ".done"},  32'(done),        32'(d));
  endtask

  logic cmp_en = 1'b1;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_addr",  32'(fetch_addr),  32'(m_addr));
      check("cyc_valid", 32'(fetch_valid), 32'(m_valid));
      check("cyc_flush", 32'(flush),       32'(m_flush_left > 0));
      check("cyc_busy",  32'(busy),        32'(m_active));
      check("cyc_done",  32'(done),        32'(m_done));
    end
  end

  initial begin
    #2 reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    expect_out("reset", 7'h00, 0, 0, 0, 0);
    reset_n = 1'b1;

    // Start and sequential fetch
    tick(0, 0, 0, 0, 7'h00);
    expect_out("idle", 7'h00, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 7'h00); expect_out("start", 7'h00, 1, 0, 1, 0);
    tick(0, 0, 0, 0, 7'h00); expect_out("seq1", 7'h01, 1, 0, 1, 0);
    tick(0, 0, 0, 0, 7'h00); expect_out("seq2", 7'h02, 1, 0, 1, 0);
    tick(0, 0, 0, 0, 7'h00); expect_out("seq3", 7'h03, 1, 0, 1, 0);
    tick(0, 0, 0, 0, 7'h00);
    tick(0, 0, 0, 0, 7'h00); expect_out("at5", 7'h05, 1, 0, 1, 0);

    // Redirect with two-cycle flush
    tick(0, 0, 0, 1, 7'h40); expect_out("br_f1", 7'h40, 0, 1, 1, 0);
    tick(0, 0, 0, 0, 7'h00); expect_out("br_f2", 7'h40, 0, 1, 1, 0);
    tick(0, 0, 0, 0, 7'h00); expect_out("br_tgt", 7'h40, 1, 0, 1, 0);
    tick(0, 0, 0, 0, 7'h00); expect_out("br_next", 7'h41, 1, 0, 1, 0);

    // Stall hold, then branch during stall; stall does not freeze the flush
    tick(0, 0, 0, 1, 7'h08);
    tick(0, 0, 0, 0, 7'h00);
    tick(0, 0, 0, 0, 7'h00);
    tick(0, 0, 0, 0, 7'h00); expect_out("at9", 7'h09, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0, 7'h00); expect_out("stall", 7'h09, 1, 0, 1, 0);
    end
    tick(0, 0, 0, 0, 7'h00); expect_out("resume", 7'h0A, 1, 0, 1, 0);
    tick(0, 1, 0, 1, 7'h20); expect_out("stall_br", 7'h20, 0, 1, 1, 0);
    tick(0, 1, 0, 0, 7'h00);
    tick(0, 1, 0, 0, 7'h00); expect_out("stall_flush_exit", 7'h20, 1, 0, 1, 0);

    // Address wrap
    tick(0, 0, 0, 1, 7'h7E);
    tick(0, 0, 0, 0, 7'h00);
    tick(0, 0, 0, 0, 7'h00); expect_out("at7e", 7'h7E, 1, 0, 1, 0);
    tick(0, 0, 0, 0, 7'h00); expect_out("at7f", 7'h7F, 1, 0, 1, 0);
    tick(0, 0, 0, 0, 7'h00); expect_out("wrap", 7'h00, 1, 0, 1, 0);

    // Branch beats halt; halt ignored during flush; lone halt; restart
    tick(0, 0, 1, 1, 7'h10); expect_out("br_halt", 7'h10, 0, 1, 1, 0);
    tick(0, 0, 1, 0, 7'h00);
    tick(0, 0, 1, 0, 7'h00); expect_out("halt_in_flush", 7'h10, 1, 0, 1, 0);
    tick(0, 0, 1, 0, 7'h00); expect_out("halted", 7'h10, 0, 0, 0, 1);
    tick(0, 0, 0, 1, 7'h55); expect_out("halted_br", 7'h10, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 7'h00); expect_out("restart", 7'h00, 1, 0, 1, 0);

    // Asynchronous reset in the middle of a flush
    tick(0, 0, 0, 1, 7'h33); expect_out("pre_rst", 7'h33, 0, 1, 1, 0);
    #2 reset_n = 1'b0;
    #1 expect_out("async_rst", 7'h00, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick(0, 0, 0, 1, 7'h12); expect_out("post_rst_idle", 7'h00, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic st, sl, hl, br;
      logic [6:0] tg;
      st = ($urandom_range(0, 99) < 6);
      sl = ($urandom_range(0, 99) < 20);
      hl = ($urandom_range(0, 99) < 3);
      br = ($urandom_range(0, 99) < 8);
      tg = 7'($urandom_range(0, 127));
      tick(st, sl, hl, br, tg);
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that sequences the instruction address presented to the local store. It drives the address and valid qualifier, and redirects on a branch taken by the odd-pipe branch unit. On a redirect it asserts a flush to the execution units for a programmable number of cycles, which kills in-flight wrong-path instructions. It sits between the top-level control, the branch unit and the local store, and replaces testbench-driven instruction addressing.

Parameters:
ADDR_W, 7, width of the instruction address (matches the local-store instruction index).
FLUSH_CYCLES, 2, number of cycles flush is held after a redirect (legal range 1..7).
START_ADDR, 0, address of the first fetch after start.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  single-cycle pulse; begins fetching from START_ADDR.
stall  in  1  hazard stall from the top level; holds the current fetch address.
halt  in  1  stop instruction decoded; ends the fetch stream.
branch_taken  in  1  redirect request from the branch unit.
branch_target  in  ADDR_W  redirect address; valid only while branch_taken=1.
fetch_addr  out  ADDR_W  instruction address to the local store.
fetch_valid  out  1  fetch_addr is a real fetch this cycle.
flush  out  1  reset/kill for the downstream execution units.
busy  out  1  state is not IDLE and not HALTED.
done  out  1  sticky; program halted.

Behaviour:
- All outputs are registered. Reset values: fetch_addr=0, fetch_valid=0, flush=0, busy=0, done=0, state=IDLE, flush counter=0.
- States are IDLE, RUN, FLUSH and HALTED (2-bit encoding).
- IDLE:
  - fetch_valid=0.
  - start=1 -> next cycle state=RUN, fetch_addr=START_ADDR, fetch_valid=1, busy=1.
  - All other inputs are ignored.
- RUN, in priority order each cycle:
  1. branch_taken=1:
     - fetch_addr <= branch_target, fetch_valid <= 0, flush <= 1.
     - Flush counter <= FLUSH_CYCLES-1; state -> FLUSH.
     - A branch overrides stall and halt in the same cycle, because the branch belongs to an older instruction. The halt is discarded.
  2. halt=1: state -> HALTED, fetch_valid <= 0, done <= 1, busy <= 0. fetch_addr holds.
  3. stall=1: fetch_addr and fetch_valid hold their values. No increment.
  4. Otherwise: fetch_addr <= fetch_addr+1, modulo 2^ADDR_W. The maximum address wraps to 0 with no error. fetch_valid <= 1.
- FLUSH:
  - flush=1 and fetch_valid=0.
  - The counter decrements each cycle, and stall does not freeze it.
  - When the counter reaches 0: flush <= 0, fetch_valid <= 1, fetch_addr keeps the target, state -> RUN. The first valid fetch is therefore the target.
  - Total flush width is exactly FLUSH_CYCLES cycles. The target is issued on cycle FLUSH_CYCLES+1 after the branch_taken edge.
  - branch_taken and halt are ignored in FLUSH, since those requests come from killed instructions.
- HALTED:
  - done=1, fetch_valid=0.
  - start=1 -> done <= 0 and the RUN entry behaves exactly as from IDLE.
- start while in RUN or FLUSH is ignored.
- Asserting reset_n low mid-operation forces the reset values immediately, including during FLUSH with flush=1. This releases flush asynchronously.
- Output latency: every output reflects its input one clock after the sampling edge. There are no combinational paths from inputs to outputs.

Optional Feature:
Macro: FETCH_SEQ_PERF_EN.
- When defined, two extra outputs are added:
  - fetch_count [15:0]: increments on every cycle with fetch_valid=1.
  - redirect_count [15:0]: increments on every accepted branch_taken.
- Both counters saturate at 16'hFFFF, reset to 0, and clear on start.
- When undefined, the ports and counters do not exist and the remaining behaviour is identical.

Decomposition:
- A shared package fetch_pkg holds:
  - the state enum FETCH_IDLE/FETCH_RUN/FETCH_FLUSH/FETCH_HALTED;
  - the default ADDR_W and FLUSH_CYCLES constants;
  - the counter width constant PERF_W=16.
- One sub-module is natural: fetch_flush_timer. It is a loadable down-counter with a zero flag, ports clk, reset_n, load, load_val, busy_o. It is reused later for mispredict recovery.

Test Plan:
1. Reset release, then start pulse, no stalls -> fetch_addr 0,1,2,3 on consecutive cycles; fetch_valid=1 from the cycle after start.
2. In RUN at addr 5, branch_taken=1 with branch_target=7'h40 -> flush=1 for exactly 2 cycles with fetch_valid=0, then fetch_addr=7'h40 with valid=1, then 7'h41.
3. stall high for 3 cycles at addr 9 -> fetch_addr holds 9 for 3 cycles and resumes at 10. branch_taken during the stall still redirects.
4. Fetch reaches 7'h7F with no stall -> the next fetch_addr is 0 and fetch_valid stays 1.
5. halt and branch_taken in the same cycle -> the branch redirect is taken and done stays 0. A later lone halt gives done=1, busy=0, and start then resumes at START_ADDR with done=0.
6. reset_n asserted in the middle of a FLUSH -> flush, fetch_valid and busy drop to 0 immediately and state=IDLE. With FETCH_SEQ_PERF_EN defined, the counters read 0.
